// File: rtl/fwd_pkg.sv
// Shared forwarding-select encoding for the hazard unit and its scoreboard.
package fwd_pkg;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF    = 2'b00;
   localparam fwd_sel_t FWD_MEMWB = 2'b01;
   localparam fwd_sel_t FWD_EXMEM = 2'b10;

endpackage

// File: rtl/fwd_scoreboard.sv
// Per-register issue-latency countdown with NUM_SRC busy read ports.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int MAX_LAT    = 4,
   parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_set_valid,
   input  logic [REG_ADDR_W-1:0]         i_set_rd,
   input  logic [LAT_W-1:0]              i_set_lat,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] i_rd_addr,
   output logic [NUM_SRC-1:0]            o_busy
);

   localparam int NREG = 2 ** REG_ADDR_W;

   logic [LAT_W-1:0] r_cnt [NREG];
   logic [LAT_W-1:0] w_setLat;

   always_comb begin
      w_setLat = i_set_lat;
      if (i_set_lat > LAT_W'(MAX_LAT)) begin
         w_setLat = LAT_W'(MAX_LAT);
      end
   end

   // A new issue overwrites any pending count on the same register (WAW).
   always_ff @(posedge clk) begin
      r_cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
         if (rst) begin
            r_cnt[r] <= '0;
         end else if (i_set_valid && (i_set_rd == REG_ADDR_W'(r)) && (w_setLat != '0)) begin
            r_cnt[r] <= w_setLat;
         end else if (r_cnt[r] != '0) begin
            r_cnt[r] <= r_cnt[r] - LAT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : gen_read
      logic [REG_ADDR_W-1:0] w_addr;
      assign w_addr    = i_rd_addr[g*REG_ADDR_W +: REG_ADDR_W];
      assign o_busy[g] = (w_addr != '0) && (r_cnt[w_addr] != '0);
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use/multi-cycle interlock and stall statistics.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int NUM_SRC     = 2,
   parameter int MAX_LAT     = 4,
   parameter int LAT_W       = $clog2(MAX_LAT + 1),
   parameter int STALL_CNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src,
   input  logic [REG_ADDR_W-1:0]         exmem_rd,
   input  logic                          exmem_wb,
   input  logic [REG_ADDR_W-1:0]         memwb_rd,
   input  logic                          memwb_wb,
   input  logic                          id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
   input  logic [NUM_SRC-1:0]            id_src_used,
   input  logic                          issue_valid,
   input  logic [REG_ADDR_W-1:0]         issue_rd,
   input  logic [LAT_W-1:0]              issue_lat,
   input  logic                          flush,
   output logic [NUM_SRC*2-1:0]          fwd_sel,
   output logic                          stall,
   output logic [STALL_CNT_W-1:0]        stall_count
);

   logic [NUM_SRC-1:0]     w_busy;
   logic [NUM_SRC-1:0]     w_need;
   logic                   w_stall;
   logic                   w_issueSet;
   logic [STALL_CNT_W-1:0] r_stallCount;

   // Issue is only honoured when ID is not being held.
   assign w_issueSet = issue_valid && !w_stall && (issue_rd != '0) && (issue_lat != '0);

   fwd_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_SRC    (NUM_SRC),
      .MAX_LAT    (MAX_LAT),
      .LAT_W      (LAT_W)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .i_set_valid (w_issueSet),
      .i_set_rd    (issue_rd),
      .i_set_lat   (issue_lat),
      .i_rd_addr   (id_src),
      .o_busy      (w_busy)
   );

   for (genvar g = 0; g < NUM_SRC; g++) begin : gen_slot
      logic [REG_ADDR_W-1:0] w_exSrc;
      logic [REG_ADDR_W-1:0] w_idSrc;
      fwd_sel_t              w_sel;

      assign w_exSrc = ex_src[g*REG_ADDR_W +: REG_ADDR_W];
      assign w_idSrc = id_src[g*REG_ADDR_W +: REG_ADDR_W];

      // EX/MEM holds the younger result, so it is tested first.
      always_comb begin
         w_sel = FWD_RF;
         if ((w_exSrc != '0) && exmem_wb && (exmem_rd == w_exSrc)) begin
            w_sel = FWD_EXMEM;
         end else if ((w_exSrc != '0) && memwb_wb && (memwb_rd == w_exSrc)) begin
            w_sel = FWD_MEMWB;
         end
      end

      assign fwd_sel[g*2 +: 2] = rst ? FWD_RF : w_sel;
      assign w_need[g]         = id_src_used[g] && (w_idSrc != '0) && w_busy[g];
   end

   assign w_stall = !rst && id_valid && !flush && (|w_need);
   assign stall   = w_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCount <= '0;
      end else if (w_stall && (r_stallCount != '1)) begin
         r_stallCount <= r_stallCount + STALL_CNT_W'(1);
      end
   end

   assign stall_count = r_stallCount;

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and interlock unit for the MIPS32 pipeline. It resolves operand forwarding for NUM_SRC source ports of the instruction in ID/EX. It also holds a per-register latency scoreboard that stalls ID on load-use and multi-cycle (mul/div) dependencies, and keeps a saturating stall-cycle counter. It sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and the hazard/stall control of the IF/ID stage.

## Interface
- REG_ADDR_W, 5: register address width; 2**REG_ADDR_W architectural registers.
- NUM_SRC, 2: source operands per instruction.
- MAX_LAT, 4: largest issue latency tracked.
- LAT_W, $clog2(MAX_LAT+1): scoreboard counter width.
- STALL_CNT_W, 16: stall statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_src  in  NUM_SRC*REG_ADDR_W  ID/EX source addresses; slot i at [i*REG_ADDR_W +: REG_ADDR_W].
- exmem_rd  in  REG_ADDR_W  EX/MEM destination.
- exmem_wb  in  1  EX/MEM writes register file.
- memwb_rd  in  REG_ADDR_W  MEM/WB destination.
- memwb_wb  in  1  MEM/WB writes register file.
- id_valid  in  1  valid instruction in IF/ID.
- id_src  in  NUM_SRC*REG_ADDR_W  IF/ID source addresses.
- id_src_used  in  NUM_SRC  per-slot "operand actually read".
- issue_valid  in  1  instruction moves ID->EX this cycle.
- issue_rd  in  REG_ADDR_W  its destination.
- issue_lat  in  LAT_W  0 = result forwardable from EX/MEM; N>0 = stall consumers N cycles (load = 1).
- flush  in  1  ID instruction squashed this cycle.
- fwd_sel  out  NUM_SRC*2  per-slot mux select.
- stall  out  1  hold IF/ID, bubble into ID/EX.
- stall_count  out  STALL_CNT_W  cycles with stall=1 since reset, saturating.

## Operation
- Forwarding, per slot i, with s = ex_src slot i:
  - s!=0 && exmem_wb && exmem_rd==s → FWD_EXMEM (2'b10).
  - else s!=0 && memwb_wb && memwb_rd==s → FWD_MEMWB (2'b01).
  - else FWD_RF (2'b00).
  - The younger result (EX/MEM) always wins. 2'b11 is never produced.
- Scoreboard: cnt[r] for r = 1..2**REG_ADDR_W-1. Register 0 is never tracked; its counter is constant 0.
  - Each cycle every nonzero cnt decrements by 1.
  - issue_valid && issue_rd!=0 && issue_lat!=0 → cnt[issue_rd] <= issue_lat. Set wins over decrement on the same register (WAW: newest latency overwrites).
  - issue_lat > MAX_LAT is clamped to MAX_LAT.
- Stall: stall = id_valid && !flush && OR over i of (id_src_used[i] && id_src_i!=0 && cnt[id_src_i]!=0).
  - issue_valid is asserted by the pipeline only when stall=0. The unit ignores issue when stall=1.
- Flush: forces stall=0 in that cycle. The scoreboard keeps counting, because in-flight producers are not killed.
- stall_count: increments when stall=1. It holds at all-ones.

## Timing
- fwd_sel and stall are combinational: 0-cycle latency from inputs and registered cnt.
- cnt and stall_count update on the rising clk edge.
- Load-use timing:
  - Load issues at cycle t (lat 1); the consumer in ID at t+1 stalls.
  - At t+2 cnt=0 and the consumer issues.
  - At t+3 the load is in MEM/WB and the consumer gets FWD_MEMWB.
- Long-latency op with lat N: a dependent in ID stalls exactly N cycles if present at t+1.
- Reset: while rst=1, fwd_sel=0 and stall=0. At the edge, all cnt ← 0 and stall_count ← 0. A reset mid-countdown discards every pending entry.

## Structure
- Package fwd_pkg holds:
  - localparams FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10;
  - the select typedef fwd_sel_t [1:0].
- Sub-module fwd_scoreboard holds the counter array, the set/decrement logic, and the per-slot busy lookup (NUM_SRC read ports). The top level contains the generate loop of forwarding comparators, stall reduction and the stats counter.

## Test plan
- ALU chain: exmem_wb=1, exmem_rd=5, ex_src slot0=5 → fwd_sel[1:0]=2'b10; same with exmem_rd=0 and slot0=0 → 2'b00.
- Priority: exmem_rd=memwb_rd=5, both wb=1, slot1=5 → fwd_sel[3:2]=2'b10; exmem_wb=0 → 2'b01.
- Load-use: issue rd=7 lat=1; next cycle id_src slot1=7, used=1 → stall=1 for exactly 1 cycle, stall_count=1. Then two cycles later with memwb_rd=7 → 2'b01.
- Long latency and WAW:
  - Issue rd=9 lat=4, consumer waiting → stall 4 cycles.
  - Repeat, but reissue rd=9 lat=3 two cycles in → stall ends 3 cycles after the reissue.
- Masking: consumer of busy r9 with id_src_used=0, or reads r0, or flush=1 → stall=0; counters still decrement.
- Reset mid-operation: rst while cnt[9]=2 and stall_count=5 → next cycle stall=0, stall_count=0, and a consumer of r9 issues immediately. Stall_count saturation is checked with STALL_CNT_W=3: it holds at 7.
